mult_sweep_checker: RTL and testbench

MULT_SWEEP_CHECKER -- requirements
Module: mult_sweep_checker

---
 rtl/mult_sweep_checker.sv | 182 ++++++++++++++++++
 tb/tb_mult_sweep_checker.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/mult_sweep_checker.sv
// Sweeps operand pairs into an external multiplier and checks its product.
// Define MULT_SWEEP_LFSR_EN to use a pseudo-random LFSR sweep instead.
module mult_sweep_checker #(
  parameter int WIDTH         = 8,
  parameter int SETTLE_CYCLES = 1
`ifdef MULT_SWEEP_LFSR_EN
  ,
  parameter int                   NUM_VECTORS = 1000,
  parameter logic [2*WIDTH-1:0]   SEED        = 1
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic [WIDTH-1:0]     A,
  output logic [WIDTH-1:0]     B,
  input  logic [2*WIDTH-1:0]   P,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [15:0]          err_count,
  output logic [4*WIDTH-1:0]   first_err
);

  localparam int PW = 2 * WIDTH;
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    SAMPLE,
    DONE
  } state_t;

  state_t           state;
  logic [3:0]       settle;
  logic [PW-1:0]    prod;
  logic             mismatch;
  logic [15:0]      err_next;
  logic             last_vec;
  logic [WIDTH-1:0] a_next;
  logic [WIDTH-1:0] b_next;
  logic [PW-1:0]    init_ab;

  // Reference product at full width, never truncated.
  assign prod     = PW'(A) * PW'(B);
  assign mismatch = (P != prod);

  // Error count saturates rather than wrapping back to a passing value.
  assign err_next = (mismatch && err_count != 16'hFFFF)
                  ? err_count + 16'd1
                  : err_count;

`ifdef MULT_SWEEP_LFSR_EN

  // Maximal-length Fibonacci tap masks, bit n-1 set for tap n.
  function automatic logic [31:0] tap_mask(input int n);
    logic [31:0] m;
    m = 32'h0;
    case (n)
      8:  m = 32'h0000_00B8;
      9:  m = 32'h0000_0110;
      10: m = 32'h0000_0240;
      11: m = 32'h0000_0500;
      12: m = 32'h0000_0829;
      13: m = 32'h0000_100D;
      14: m = 32'h0000_2015;
      15: m = 32'h0000_6000;
      16: m = 32'h0000_D008;
      17: m = 32'h0001_2000;
      18: m = 32'h0002_0400;
      19: m = 32'h0004_0023;
      20: m = 32'h0009_0000;
      21: m = 32'h0014_0000;
      22: m = 32'h0030_0000;
      23: m = 32'h0042_0000;
      24: m = 32'h00E1_0000;
      25: m = 32'h0120_0000;
      26: m = 32'h0200_0023;
      27: m = 32'h0400_0013;
      28: m = 32'h0900_0000;
      29: m = 32'h1400_0000;
      30: m = 32'h2000_0029;
      31: m = 32'h4800_0000;
      32: m = 32'h8020_0003;
      default: m = 32'h0;
    endcase
    return m;
  endfunction

  localparam logic [PW-1:0] TAPS = PW'(tap_mask(PW));

  logic [PW-1:0] cur_ab;
  logic [PW-1:0] lfsr_next;
  logic [31:0]   vec_cnt;

  // The operand pair itself is the LFSR state.
  assign cur_ab    = {A, B};
  assign lfsr_next = {cur_ab[PW-2:0], ^(cur_ab & TAPS)};
  assign a_next    = lfsr_next[PW-1:WIDTH];
  assign b_next    = lfsr_next[WIDTH-1:0];
  assign last_vec  = (vec_cnt == 32'(NUM_VECTORS - 1));
  assign init_ab   = SEED;

  // Vector counter for the pseudo-random sweep length.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec_cnt <= 32'd0;
    end else if ((state == IDLE || state == DONE) && start) begin
      vec_cnt <= 32'd0;
    end else if (state == SAMPLE && !last_vec) begin
      vec_cnt <= vec_cnt + 32'd1;
    end
  end

`else

  // Exhaustive order: B is the fast index, A advances on B wrap.
  assign b_next   = B + WIDTH'(1);
  assign a_next   = (B == '1) ? A + WIDTH'(1) : A;
  assign last_vec = (A == '1) && (B == '1);
  assign init_ab  = '0;

`endif

  // Sweep control FSM with registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      A         <= '0;
      B         <= '0;
      settle    <= 4'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= 16'd0;
      first_err <= '0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            state     <= DRIVE;
            A         <= init_ab[PW-1:WIDTH];
            B         <= init_ab[WIDTH-1:0];
            settle    <= 4'd0;
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= 16'd0;
            first_err <= '0;
          end
        end
        DRIVE: begin
          if (settle == SETTLE_LAST) begin
            settle <= 4'd0;
            state  <= SAMPLE;
          end else begin
            settle <= settle + 4'd1;
          end
        end
        SAMPLE: begin
          err_count <= err_next;
          if (mismatch && err_count == 16'd0) begin
            first_err <= {A, B, P};
          end
          if (last_vec) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_next == 16'd0);
          end else begin
            A     <= a_next;
            B     <= b_next;
            state <= DRIVE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_sweep_checker.sv
// Bench for mult_sweep_checker: two instances (settle 1 and 3),
// a faultable multiplier and a cycle-count based reference model.
module tb_mult_sweep_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start;
  int          mode;
  logic        chk_en;

  logic [3:0]  a1, b1, a3, b3;
  logic [7:0]  p1, p3;
  logic        bz1, dn1, ps1, bz3, dn3, ps3;
  logic [15:0] ec1, ec3, fe1, fe3;

  int checks = 0;
  int errors = 0;

  // Multiplier under test: 0 ideal, 1 zero at 3*5, 2 bit 7 stuck low.
  function automatic logic [7:0] mul(input int md, input logic [3:0] a,
                                     input logic [3:0] b);
    logic [7:0] r;
    r = 8'(a) * 8'(b);
    if (md == 1 && a == 4'd3 && b == 4'd5) r = 8'd0;
    if (md == 2) r[7] = 1'b0;
    return r;
  endfunction

  always_comb p1 = mul(mode, a1, b1);
  always_comb p3 = mul(mode, a3, b3);

  mult_sweep_checker #(.WIDTH(4), .SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .start(start),
    .A(a1), .B(b1), .P(p1),
    .busy(bz1), .done(dn1), .pass(ps1),
    .err_count(ec1), .first_err(fe1)
  );

  mult_sweep_checker #(.WIDTH(4), .SETTLE_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst), .start(start),
    .A(a3), .B(b3), .P(p3),
    .busy(bz3), .done(dn3), .pass(ps3),
    .err_count(ec3), .first_err(fe3)
  );

  task automatic cmp(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: 0 idle, 1 sweeping, 2 finished; n = edges since start.
  int mst[2];
  int n[2];
  int mmode[2];
  int per[2];

  initial begin
    per[0] = 2;
    per[1] = 4;
    for (int k = 0; k < 2; k++) begin
      mst[k] = 0;
      n[k] = 0;
      mmode[k] = 0;
    end
  end

  always @(posedge clk or posedge rst) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        mst[k] = 0;
      end else if (mst[k] != 1 && start) begin
        mst[k] = 1;
        n[k] = 0;
        mmode[k] = mode;
      end else if (mst[k] == 1) begin
        n[k]++;
        if (n[k] == 256 * per[k]) mst[k] = 2;
      end
    end
  end

  task automatic chk(input int k, input logic [3:0] a, input logic [3:0] b,
                     input logic bz, input logic dn, input logic ps,
                     input logic [15:0] ec, input logic [15:0] fe);
    int comp, idx, e, f;
    logic [31:0] xfe;
    string p;
    e = 0;
    f = -1;
    comp = 0;
    idx = 0;
    if (mst[k] != 0) begin
      comp = (mst[k] == 2) ? 256 : n[k] / per[k];
      for (int i = 0; i < comp; i++) begin
        if (mul(mmode[k], 4'(i >> 4), 4'(i & 15)) != 8'((i >> 4) * (i & 15))) begin
          e++;
          if (f < 0) f = i;
        end
      end
      idx = (mst[k] == 2) ? 255 : comp;
    end
    xfe = (f < 0) ? 32'd0
        : {16'd0, 4'(f >> 4), 4'(f & 15), mul(mmode[k], 4'(f >> 4), 4'(f & 15))};
    p = (k == 0) ? "s1" : "s3";
    cmp({p, ".A"}, 32'(a), 32'(idx >> 4));
    cmp({p, ".B"}, 32'(b), 32'(idx & 15));
    cmp({p, ".busy"}, 32'(bz), 32'(mst[k] == 1));
    cmp({p, ".done"}, 32'(dn), 32'(mst[k] == 2));
    cmp({p, ".pass"}, 32'(ps), 32'(mst[k] == 2 && e == 0));
    cmp({p, ".err_count"}, 32'(ec), 32'(e));
    cmp({p, ".first_err"}, 32'(fe), xfe);
  endtask

  // Compare both instances against the model every cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      chk(0, a1, b1, bz1, dn1, ps1, ec1, fe1);
      chk(1, a3, b3, bz3, dn3, ps3, ec3, fe3);
    end
  end

  task automatic pulse_start;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Count edges after the start edge until each instance reports done.
  task automatic wait_done(input bit mid, output int t1, output int t3);
    t1 = -1;
    t3 = -1;
    for (int c = 1; c <= 3000 && t3 < 0; c++) begin
      @(posedge clk);
      #1;
      if (dn1 && t1 < 0) t1 = c;
      if (dn3 && t3 < 0) t3 = c;
      if (mid && c == 100) start = 1'b1;
      if (mid && c == 101) start = 1'b0;
    end
    cmp("done_seen", 32'(dn3), 32'd1);
  endtask

  task automatic zeros(input string nm);
    cmp({nm, ".s1"}, {a1, b1, bz1, dn1, ps1, ec1, fe1}, 32'd0);
    cmp({nm, ".s3"}, {a3, b3, bz3, dn3, ps3, ec3, fe3}, 32'd0);
  endtask

  int  t1, t3;
  bit  found;

  initial begin
    rst = 1'b0;
    start = 1'b0;
    mode = 0;
    chk_en = 1'b0;
    #1 rst = 1'b1;
    #3;
    zeros("reset_state");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
    repeat (5) @(negedge clk);

    // Ideal multiplier, with a second start ignored mid-sweep.
    pulse_start();
    wait_done(1'b1, t1, t3);
    cmp("latency_settle1", 32'(t1), 32'd512);
    cmp("latency_settle3", 32'(t3), 32'd1024);
    cmp("ideal_pass", 32'(ps1), 32'd1);
    cmp("ideal_err", 32'(ec1), 32'd0);
    repeat (20) @(negedge clk);
    cmp("hold_done", 32'(dn1), 32'd1);

    // Single bad vector at 3*5; restart straight from DONE.
    mode = 1;
    pulse_start();
    wait_done(1'b0, t1, t3);
    cmp("one_bad_err", 32'(ec1), 32'd1);
    cmp("one_bad_pass", 32'(ps1), 32'd0);
    cmp("one_bad_first", 32'(fe1), 32'h3500);
    cmp("one_bad_first_s3", 32'(fe3), 32'h3500);

    // Bit 7 stuck low: every product >= 128 is wrong.
    mode = 2;
    pulse_start();
    wait_done(1'b0, t1, t3);
    cmp("stuck_err", 32'(ec1), 32'd32);
    cmp("stuck_first", 32'(fe1), 32'h9F07);
    cmp("stuck_pass", 32'(ps3), 32'd0);

    // Reset in the middle of a sweep at A=7, B=9.
    mode = 0;
    pulse_start();
    found = 1'b0;
    for (int c = 0; c < 1000 && !found; c++) begin
      @(posedge clk);
      #1;
      if (a1 == 4'd7 && b1 == 4'd9 && bz1) found = 1'b1;
    end
    cmp("reach_7_9", 32'(found), 32'd1);
    #2 rst = 1'b1;
    #1;
    zeros("mid_reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    zeros("idle_after_reset");
    pulse_start();
    cmp("restart_ab", {24'd0, a1, b1}, 32'd0);
    cmp("restart_busy", 32'(bz1), 32'd1);
    wait_done(1'b0, t1, t3);
    cmp("restart_latency", 32'(t1), 32'd512);
    cmp("restart_pass", 32'(ps3), 32'd1);

    repeat (2) @(negedge clk);
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
